alu_seq: RTL and testbench

Parametrised, handshaked successor to the processor's combinational arithmetic unit. Keeps the existing 3-bit operation codes and adds subtract and unsigned divide/remainder. Multiply and divide run as iterative multi-cycle operations, and results and flags are registered. Sits between decode/issue and writeback, and stalls issue through `in_ready`.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_iter_muldiv.sv | 105 ++++++++++
 rtl/alu_seq.sv | 189 ++++++++++++++++++
 tb/tb_alu_seq.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and FSM state type for the sequential ALU.
// Imported by the top level and the test bench.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_PASS = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier / restoring divider.
// One bit per cycle; shares accumulator, shift reg and counter.
module alu_iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic             rem_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             div_q, div_d;
  logic             rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Restoring-division trial: shifted remainder against divisor.
  always_comb begin
    part = {acc_q, sh_q[WIDTH-1]};
    ge   = part >= {1'b0, opd_q};
    diff = part[WIDTH-1:0] - opd_q;
  end

  // Next-state for counter and shared datapath registers.
  always_comb begin
    cnt_d = cnt_q;
    run_d = run_q;
    div_d = div_q;
    rem_d = rem_q;
    acc_d = acc_q;
    sh_d  = sh_q;
    opd_d = opd_q;
    if (start) begin
      cnt_d = CNT_W'(WIDTH);
      run_d = 1'b1;
      div_d = is_div;
      rem_d = rem_sel;
      acc_d = '0;
      sh_d  = is_div ? op_a : op_b;
      opd_d = is_div ? op_b : op_a;
    end else if (run_q) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        run_d = 1'b0;
      end
      if (div_q) begin
        acc_d = ge ? diff : part[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], ge};
      end else begin
        if (sh_q[0]) begin
          acc_d = acc_q + opd_q;
        end
        opd_d = opd_q << 1;
        sh_d  = sh_q >> 1;
      end
    end
  end

  // Final iteration: hand the post-step value straight to the top.
  always_comb begin
    done   = run_q && (cnt_q == CNT_W'(1));
    result = div_q ? (rem_q ? acc_d : sh_d) : acc_d;
  end

  // Control registers: counter, busy, op kind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      div_q <= 1'b0;
      rem_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      div_q <= div_d;
      rem_q <= rem_d;
    end
  end

  // Datapath registers: accumulator, shift reg, operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      opd_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      opd_q <= opd_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, single-cycle ops, flags.
// Mul/div are delegated to alu_iter_muldiv.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic [WIDTH-1:0] sc_y;
  logic             sc_c, sc_o, sc_d;
  logic             is_mul, is_dv, b_zero;
  logic             start;
  logic             it_done;
  logic [WIDTH-1:0] it_res;

  alu_iter_muldiv #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .is_div (is_dv),
    .rem_sel(select == OP_REMU),
    .op_a   (data_a),
    .op_b   (data_b),
    .done   (it_done),
    .result (it_res)
  );

  // Single-cycle results and flags, including divide-by-zero.
  always_comb begin
    sum  = {1'b0, data_a} + {1'b0, data_b};
    dif  = {1'b0, data_a} + {1'b0, ~data_b}
         + {{WIDTH{1'b0}}, 1'b1};
    sc_y = '0;
    sc_c = 1'b0;
    sc_o = 1'b0;
    sc_d = 1'b0;
    case (select)
      OP_ADD: begin
        sc_y = sum[WIDTH-1:0];
        sc_c = sum[WIDTH];
        sc_o = (data_a[MSB] == data_b[MSB])
            && (sum[MSB] != data_a[MSB]);
      end
      OP_SUB: begin
        sc_y = dif[WIDTH-1:0];
        sc_c = dif[WIDTH];
        sc_o = (data_a[MSB] != data_b[MSB])
            && (dif[MSB] != data_a[MSB]);
      end
      OP_AND:  sc_y = data_a & data_b;
      OP_OR:   sc_y = data_a | data_b;
      OP_XOR:  sc_y = data_a ^ data_b;
      OP_SLTU: sc_y = {{(WIDTH-1){1'b0}}, data_a < data_b};
      OP_PASS: sc_y = data_a;
      OP_DIVU: begin
        sc_y = '1;
        sc_d = 1'b1;
      end
      OP_REMU: begin
        sc_y = data_a;
        sc_d = 1'b1;
      end
      default: sc_y = '0;
    endcase
  end

  // Op classification for the issue decision.
  always_comb begin
    is_mul = select == OP_MUL;
    is_dv  = is_div_op(select);
    b_zero = data_b == '0;
  end

  // FSM next state, iterative start, result/flag capture.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          unique case (1'b1)
            is_mul: begin
              start   = 1'b1;
              state_d = S_MUL;
            end
            is_dv && !b_zero: begin
              start   = 1'b1;
              state_d = S_DIV;
            end
            default: begin
              y_d     = sc_y;
              zero_d  = sc_y == '0;
              carry_d = sc_c;
              ovf_d   = sc_o;
              dbz_d   = sc_d;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (it_done) begin
          y_d     = it_res;
          zero_d  = it_res == '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Result and flag registers, frozen while DONE waits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      y_q     <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      y_q     <= y_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = state_q == S_IDLE;
  assign out_valid   = state_q == S_DONE;
  assign y           = y_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=32 and WIDTH=8.
// Random ops are checked against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iv = 1'b0;
  logic        ordy = 1'b0;
  logic        sel8 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [3:0]  sel = '0;

  logic        iv32, iv8, or32, or8;
  logic        ir32, ov32, z32, c32, o32, d32;
  logic        ir8, ov8, z8, c8, o8, d8;
  logic [31:0] y32;
  logic [7:0]  y8;
  logic        ir_o, ov_o, z_o, c_o, o_o, d_o;
  logic [31:0] y_o;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign iv32 = iv & ~sel8;
  assign iv8  = iv & sel8;
  assign or32 = ordy & ~sel8;
  assign or8  = ordy & sel8;
  assign ir_o = sel8 ? ir8 : ir32;
  assign ov_o = sel8 ? ov8 : ov32;
  assign y_o  = sel8 ? {24'd0, y8} : y32;
  assign z_o  = sel8 ? z8 : z32;
  assign c_o  = sel8 ? c8 : c32;
  assign o_o  = sel8 ? o8 : o32;
  assign d_o  = sel8 ? d8 : d32;

  alu_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset),
    .in_valid(iv32), .in_ready(ir32),
    .data_a(a), .data_b(b), .select(sel),
    .out_valid(ov32), .out_ready(or32),
    .y(y32), .zero(z32), .carry(c32),
    .overflow(o32), .div_by_zero(d32)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(iv8), .in_ready(ir8),
    .data_a(a[7:0]), .data_b(b[7:0]), .select(sel),
    .out_valid(ov8), .out_ready(or8),
    .y(y8), .zero(z8), .carry(c8),
    .overflow(o8), .div_by_zero(d8)
  );

  // Reference: plain arithmetic on masked operands.
  function automatic void model(
    input int w, input logic [3:0] op,
    input logic [31:0] ai, input logic [31:0] bi,
    output logic [31:0] ry, output logic rz,
    output logic rc, output logic ro, output logic rd,
    output int lat);
    logic [63:0] m, ua, ub, r;
    longint sa, sb, s, hi, lo;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, ai} & m;
    ub = {32'd0, bi} & m;
    sa = ua[w-1] ? longint'(ua) - longint'(m) - 1 : longint'(ua);
    sb = ub[w-1] ? longint'(ub) - longint'(m) - 1 : longint'(ub);
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    r = 0; rc = 0; ro = 0; rd = 0; lat = 1;
    case (op)
      4'd1: begin
        r = ua + ub; rc = r[w];
        s = sa + sb; ro = (s > hi) || (s < lo);
      end
      4'd8: begin
        r = ua - ub; rc = ua >= ub;
        s = sa - sb; ro = (s > hi) || (s < lo);
      end
      4'd2: r = ua & ub;
      4'd3: r = ua | ub;
      4'd4: r = ua ^ ub;
      4'd5: r = (ua < ub) ? 64'd1 : 64'd0;
      4'd6: begin r = ua * ub; lat = w + 1; end
      4'd7: r = ua;
      4'd9: if (ub == 0) begin r = m; rd = 1; end
            else begin r = ua / ub; lat = w + 1; end
      4'd10: if (ub == 0) begin r = ua; rd = 1; end
             else begin r = ua % ub; lat = w + 1; end
      default: r = 0;
    endcase
    r  = r & m;
    ry = r[31:0];
    rz = (ry == 32'd0);
  endfunction

  // Drive one op, scramble inputs after accept, wait, consume.
  task automatic run_op(
    input bit w8, input logic [3:0] op,
    input logic [31:0] da, input logic [31:0] db,
    output logic [31:0] ry, output logic rz,
    output logic rc, output logic ro, output logic rd,
    output int lat, output int irhi);
    int k;
    sel8 = w8;
    @(negedge clk);
    k = 0;
    while (!ir_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    a = da; b = db; sel = op; iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    a = $urandom; b = $urandom; sel = 4'($urandom);
    lat = 0; irhi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (ir_o) irhi++;
    end while (!ov_o && lat < 200);
    ry = y_o; rz = z_o; rc = c_o; ro = o_o; rd = d_o;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    if (y32 !== 32'd0) begin n_fail++; $display("FAIL rst_y got %h want 0", y32); end n_cmp++;
    if ({z32, c32, o32, d32, ov32} !== 5'd0) begin n_fail++; $display("FAIL rst_flags got %b want 00000", {z32, c32, o32, d32, ov32}); end n_cmp++;
    if ({y8, z8, c8, o8, d8, ov8} !== 13'd0) begin n_fail++; $display("FAIL rst_w8 got %h want 0", {y8, z8, c8, o8, d8, ov8}); end n_cmp++;
    reset = 1'b0;
    @(negedge clk);
    if (ir32 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", ir32); end n_cmp++;
    if (ir8 !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready8 got %b want 1", ir8); end n_cmp++;
  endtask

  task automatic test_directed;
    logic [31:0] ry;
    logic rz, rc, ro, rd;
    int lat, irhi;
    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'd1, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rz, rc, ro} !== {32'h8000_0000, 3'b001}) begin n_fail++; $display("FAIL add_ovf got %h z%b c%b o%b want 80000000 z0 c0 o1", ry, rz, rc, ro); end n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL add_lat got %0d want 1", lat); end n_cmp++;
    run_op(0, OP_SUB, 32'd5, 32'd5, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rz, rc, ro} !== {32'd0, 3'b110}) begin n_fail++; $display("FAIL sub_eq got %h z%b c%b o%b want 0 z1 c1 o0", ry, rz, rc, ro); end n_cmp++;
    run_op(0, OP_SLTU, 32'd3, 32'hFFFF_FFFF, ry, rz, rc, ro, rd, lat, irhi);
    if (ry !== 32'd1) begin n_fail++; $display("FAIL sltu got %h want 1", ry); end n_cmp++;
    run_op(0, OP_MUL, 32'h0001_0003, 32'h0001_0002, ry, rz, rc, ro, rd, lat, irhi);
    if (ry !== 32'h0005_0006) begin n_fail++; $display("FAIL mul_y got %h want 00050006", ry); end n_cmp++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_lat got %0d want 33", lat); end n_cmp++;
    if (irhi !== 0) begin n_fail++; $display("FAIL mul_in_ready got %0d high cycles want 0", irhi); end n_cmp++;
    run_op(0, OP_DIVU, 32'd100, 32'd7, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rd} !== {32'd14, 1'b0}) begin n_fail++; $display("FAIL divu got %h dbz%b want 0000000e dbz0", ry, rd); end n_cmp++;
    if (lat !== 33) begin n_fail++; $display("FAIL divu_lat got %0d want 33", lat); end n_cmp++;
    run_op(0, OP_REMU, 32'd100, 32'd7, ry, rz, rc, ro, rd, lat, irhi);
    if (ry !== 32'd2) begin n_fail++; $display("FAIL remu got %h want 2", ry); end n_cmp++;
    run_op(0, OP_DIVU, 32'd100, 32'd0, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rd} !== {32'hFFFF_FFFF, 1'b1}) begin n_fail++; $display("FAIL div0 got %h dbz%b want ffffffff dbz1", ry, rd); end n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL div0_lat got %0d want 1", lat); end n_cmp++;
    run_op(0, OP_REMU, 32'h1234, 32'd0, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rd} !== {32'h1234, 1'b1}) begin n_fail++; $display("FAIL rem0 got %h dbz%b want 00001234 dbz1", ry, rd); end n_cmp++;
    run_op(0, 4'hF, 32'h55, 32'h66, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rz} !== {32'd0, 1'b1} || lat !== 1) begin n_fail++; $display("FAIL bad_op got %h z%b lat%0d want 0 z1 lat1", ry, rz, lat); end n_cmp++;
  endtask

  task automatic test_random(input bit w8, input int n);
    logic [31:0] ra, rb, ry, ey;
    logic [3:0] op;
    logic rz, rc, ro, rd, ez, ec, eo, ed;
    int lat, elat, irhi, w;
    w = w8 ? 8 : 32;
    for (int i = 0; i < n; i++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb & 32'hF;
      if (w8) begin ra = ra & 32'hFF; rb = rb & 32'hFF; end
      model(w, op, ra, rb, ey, ez, ec, eo, ed, elat);
      run_op(w8, op, ra, rb, ry, rz, rc, ro, rd, lat, irhi);
      if (ry !== ey) begin n_fail++; $display("FAIL rnd_y w%0d op%h a%h b%h got %h want %h", w, op, ra, rb, ry, ey); end n_cmp++;
      if ({rz, rc, ro, rd} !== {ez, ec, eo, ed}) begin n_fail++; $display("FAIL rnd_flags w%0d op%h a%h b%h got %b want %b", w, op, ra, rb, {rz, rc, ro, rd}, {ez, ec, eo, ed}); end n_cmp++;
      if (lat !== elat) begin n_fail++; $display("FAIL rnd_lat w%0d op%h got %0d want %0d", w, op, lat, elat); end n_cmp++;
      if (irhi !== 0) begin n_fail++; $display("FAIL rnd_in_ready w%0d op%h got %0d high cycles want 0", w, op, irhi); end n_cmp++;
    end
  endtask

  task automatic test_backpressure;
    int k;
    sel8 = 1'b0;
    @(negedge clk);
    a = 32'hA5A5_0F0F; b = 32'h0FF0_FFFF; sel = OP_XOR;
    iv = 1'b1; ordy = 1'b0;
    @(posedge clk);
    #1;
    a = 32'd2; b = 32'd3; sel = OP_ADD;
    k = 0;
    repeat (11) begin
      @(negedge clk);
      if (ov32 !== 1'b1 || y32 !== 32'hAA55_F0F0) begin n_fail++; $display("FAIL bp_hold cyc%0d got v%b y%h want v1 y aa55f0f0", k, ov32, y32); end n_cmp++;
      if (ir32 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready cyc%0d got %b want 0", k, ir32); end n_cmp++;
      k++;
    end
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
    @(negedge clk);
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin n_fail++; $display("FAIL bp_idle got r%b v%b want r1 v0", ir32, ov32); end n_cmp++;
    @(posedge clk);
    #1;
    iv = 1'b0;
    @(negedge clk);
    if (ov32 !== 1'b1 || y32 !== 32'd5) begin n_fail++; $display("FAIL bp_second got v%b y%h want v1 y5", ov32, y32); end n_cmp++;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    ordy = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] ry;
    logic rz, rc, ro, rd;
    int lat, irhi;
    run_op(0, OP_SUB, 32'd3, 32'd9, ry, rz, rc, ro, rd, lat, irhi);
    sel8 = 1'b0;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1234_5678; sel = OP_MUL; iv = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (10) @(negedge clk);
    if (ov32 !== 1'b0 || ir32 !== 1'b0) begin n_fail++; $display("FAIL mid_busy got v%b r%b want v0 r0", ov32, ir32); end n_cmp++;
    if (y32 !== 32'hFFFF_FFFA || c32 !== 1'b0 || o32 !== 1'b0) begin n_fail++; $display("FAIL mid_prev got y%h c%b o%b want fffffffa c0 o0", y32, c32, o32); end n_cmp++;
    #2;
    reset = 1'b1;
    #1;
    if (y32 !== 32'd0) begin n_fail++; $display("FAIL mid_rst_y got %h want 0", y32); end n_cmp++;
    if ({z32, c32, o32, d32, ov32} !== 5'd0) begin n_fail++; $display("FAIL mid_rst_flags got %b want 00000", {z32, c32, o32, d32, ov32}); end n_cmp++;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin n_fail++; $display("FAIL mid_release got r%b v%b want r1 v0", ir32, ov32); end n_cmp++;
    run_op(0, OP_MUL, 32'd7, 32'd6, ry, rz, rc, ro, rd, lat, irhi);
    if (ry !== 32'd42 || lat !== 33) begin n_fail++; $display("FAIL mid_after got y%h lat%0d want 2a lat33", ry, lat); end n_cmp++;
  endtask

  task automatic test_w8;
    logic [31:0] ry;
    logic rz, rc, ro, rd;
    int lat, irhi;
    run_op(1, OP_MUL, 32'h0F, 32'h11, ry, rz, rc, ro, rd, lat, irhi);
    if (ry !== 32'hFF || rz !== 1'b0) begin n_fail++; $display("FAIL w8_mul got %h z%b want ff z0", ry, rz); end n_cmp++;
    if (lat !== 9) begin n_fail++; $display("FAIL w8_mul_lat got %0d want 9", lat); end n_cmp++;
    run_op(1, OP_ADD, 32'h7F, 32'h01, ry, rz, rc, ro, rd, lat, irhi);
    if ({ry, rc, ro} !== {32'h80, 2'b01}) begin n_fail++; $display("FAIL w8_add got %h c%b o%b want 80 c0 o1", ry, rc, ro); end n_cmp++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(1'b0, 40);
    test_reset_mid();
    test_w8();
    test_random(1'b1, 30);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
